// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback stage.
package regfile_pkg;

    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned NumRegs      = 32;
    localparam int unsigned WbDataWidth  = 32;

    // One queued register-file write.
    typedef struct packed {
        logic [RegAddrWidth-1:0] rd;
        logic [WbDataWidth-1:0]  wdata;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } wb_state_e;

    // One-hot decode of a destination register index.
    function automatic logic [NumRegs-1:0] rd_onehot(input logic [RegAddrWidth-1:0] rd);
        logic [NumRegs-1:0] v;
        v     = '0;
        v[rd] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_stage_if.sv
// Result-in / register-file-out / hazard-lookup bundle of the writeback stage.
interface regfile_wb_stage_if
    import regfile_pkg::*;
#(
    parameter int unsigned DataWidth = WbDataWidth
);
    logic                    alu_valid_i;
    logic                    alu_ready_o;
    logic [RegAddrWidth-1:0] alu_rd_i;
    logic [DataWidth-1:0]    alu_wdata_i;

    logic                    lsu_valid_i;
    logic                    lsu_ready_o;
    logic [RegAddrWidth-1:0] lsu_rd_i;
    logic [DataWidth-1:0]    lsu_wdata_i;

    logic                    rf_req_w_o;
    logic [RegAddrWidth-1:0] rf_waddr_o;
    logic [DataWidth-1:0]    rf_wdata_o;

    logic [NumRegs-1:0]      pend_mask_o;

    logic [RegAddrWidth-1:0] fwd_addr_i;
    logic                    fwd_hit_o;
    logic [DataWidth-1:0]    fwd_data_o;

    // Writeback stage side.
    modport slave (
        input  alu_valid_i, alu_rd_i, alu_wdata_i,
        input  lsu_valid_i, lsu_rd_i, lsu_wdata_i,
        input  fwd_addr_i,
        output alu_ready_o, lsu_ready_o,
        output rf_req_w_o, rf_waddr_o, rf_wdata_o,
        output pend_mask_o, fwd_hit_o, fwd_data_o
    );

    // Producer / consumer side (execution units, decode, register file).
    modport master (
        output alu_valid_i, alu_rd_i, alu_wdata_i,
        output lsu_valid_i, lsu_rd_i, lsu_wdata_i,
        output fwd_addr_i,
        input  alu_ready_o, lsu_ready_o,
        input  rf_req_w_o, rf_waddr_o, rf_wdata_o,
        input  pend_mask_o, fwd_hit_o, fwd_data_o
    );

endinterface

// File: rtl/wb_queue.sv
// In-order result queue: up to two pushes (entry0 older) and one pop per cycle,
// with an oldest-first view of all slots for mask and forwarding logic.
module wb_queue
    import regfile_pkg::*;
#(
    parameter  int unsigned Depth = 4,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push0,
    input  wb_entry_t       i_entry0,
    input  logic            i_push1,
    input  wb_entry_t       i_entry1,
    input  logic            i_pop,
    output wb_entry_t       o_head,
    output logic [CntW-1:0] o_count,
    output wb_entry_t       o_entries [Depth],
    output logic [Depth-1:0] o_valid
);

    wb_entry_t       r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic [CntW-1:0] w_n_push;

    assign w_n_push = CntW'(i_push0) + CntW'(i_push1);

    // Pointer and occupancy tracking; pointers wrap modulo Depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push0 && i_push1) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(2);
            end else if (i_push0) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= r_count + w_n_push - CntW'(i_pop);
        end
    end

    // Entry storage; contents are don't-care until the count covers them.
    always_ff @(posedge i_clk) begin
        if (i_push0) begin
            r_mem[r_wr_ptr] <= i_entry0;
        end
        if (i_push1) begin
            r_mem[r_wr_ptr + PtrW'(1)] <= i_entry1;
        end
    end

    // Oldest-first view of the queue contents.
    always_comb begin
        for (int k = 0; k < Depth; k++) begin
            o_entries[k] = r_mem[r_rd_ptr + PtrW'(k)];
            o_valid[k]   = (CntW'(k) < r_count);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/regfile_wb_stage.sv
// Writeback stage: queues ALU/LSU results and replays them to the register
// file as setup-then-strobe writes; exposes pending mask and forwarding.
module regfile_wb_stage
    import regfile_pkg::*;
#(
    parameter int unsigned DataWidth = WbDataWidth,
    parameter int unsigned Depth     = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    regfile_wb_stage_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    wb_state_e               r_state;
    logic                    r_req_w;
    logic [RegAddrWidth-1:0] r_waddr;
    logic [DataWidth-1:0]    r_wdata;

    logic [CntW-1:0]  w_count;
    logic [CntW-1:0]  w_free;
    wb_entry_t        w_head;
    wb_entry_t        w_entries [Depth];
    logic [Depth-1:0] w_valid;

    logic      w_lsu_push;
    logic      w_alu_push;
    logic      w_push0;
    logic      w_push1;
    wb_entry_t w_entry0;
    wb_entry_t w_entry1;
    logic      w_pop;
    logic      w_inflight;

    logic [NumRegs-1:0]   w_mask;
    logic                 w_fwd_hit;
    logic [DataWidth-1:0] w_fwd_data;

    // Ready depends only on occupancy and lsu_valid_i; the LSU has first claim.
    always_comb begin
        w_free          = CntW'(Depth) - w_count;
        bus.lsu_ready_o = (w_free >= CntW'(1));
        bus.alu_ready_o = bus.lsu_valid_i ? (w_free >= CntW'(2)) : (w_free >= CntW'(1));
    end

    // Accepted results to x0 are swallowed; LSU entry goes ahead of ALU entry.
    always_comb begin
        w_lsu_push = bus.lsu_valid_i && bus.lsu_ready_o && (bus.lsu_rd_i != '0);
        w_alu_push = bus.alu_valid_i && bus.alu_ready_o && (bus.alu_rd_i != '0);
        w_push0    = w_lsu_push || w_alu_push;
        w_push1    = w_lsu_push && w_alu_push;
        w_entry1   = '{rd: bus.alu_rd_i, wdata: bus.alu_wdata_i};
        w_entry0   = w_lsu_push ? '{rd: bus.lsu_rd_i, wdata: bus.lsu_wdata_i} : w_entry1;
    end

    // Head leaves the queue whenever the write port is free to take it.
    assign w_pop      = ((r_state == IDLE) || (r_state == STROBE)) && (w_count != '0);
    assign w_inflight = (r_state != IDLE);

    wb_queue #(
        .Depth (Depth)
    ) u_queue (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_push0   (w_push0),
        .i_entry0  (w_entry0),
        .i_push1   (w_push1),
        .i_entry1  (w_entry1),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    // Write sequencer: load address/data, hold a setup cycle, then strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req_w <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_w <= 1'b0;
                    if (w_pop) begin
                        r_waddr <= w_head.rd;
                        r_wdata <= w_head.wdata;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_req_w <= 1'b1;
                    r_state <= STROBE;
                end
                STROBE: begin
                    r_req_w <= 1'b0;
                    if (w_pop) begin
                        r_waddr <= w_head.rd;
                        r_wdata <= w_head.wdata;
                        r_state <= SETUP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_req_w <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Pending destinations: every queued entry plus the one being written.
    always_comb begin
        w_mask = '0;
        if (w_inflight) begin
            w_mask = w_mask | rd_onehot(r_waddr);
        end
        for (int k = 0; k < Depth; k++) begin
            if (w_valid[k]) begin
                w_mask = w_mask | rd_onehot(w_entries[k].rd);
            end
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (bus.fwd_addr_i != '0) begin
            if (w_inflight && (r_waddr == bus.fwd_addr_i)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_wdata;
            end
            for (int k = 0; k < Depth; k++) begin
                if (w_valid[k] && (w_entries[k].rd == bus.fwd_addr_i)) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = w_entries[k].wdata;
                end
            end
        end
    end

    assign bus.rf_req_w_o  = r_req_w;
    assign bus.rf_waddr_o  = r_waddr;
    assign bus.rf_wdata_o  = r_wdata;
    assign bus.pend_mask_o = w_mask;
    assign bus.fwd_hit_o   = w_fwd_hit;
    assign bus.fwd_data_o  = w_fwd_data;

endmodule

// File: tb/tb_regfile_wb_stage.sv
// Directed bench for regfile_wb_stage (DataWidth 32, Depth 4).
module tb_regfile_wb_stage;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;

    logic [4:0]  log_addr [$];
    logic [31:0] log_data [$];
    int          log_cyc  [$];

    regfile_wb_stage_if #(.DataWidth(32)) bus ();

    regfile_wb_stage #(
        .DataWidth (32),
        .Depth     (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every register-file write strobe, away from the active edge.
    always @(negedge clk) begin
        if (!rst && bus.rf_req_w_o) begin
            log_addr.push_back(bus.rf_waddr_o);
            log_data.push_back(bus.rf_wdata_o);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid_i = 1'b0;
        bus.alu_rd_i    = '0;
        bus.alu_wdata_i = '0;
        bus.lsu_valid_i = 1'b0;
        bus.lsu_rd_i    = '0;
        bus.lsu_wdata_i = '0;
        bus.fwd_addr_i  = '0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.rf_req_w_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b expected 0", bus.rf_req_w_o); end
        n_cmp++; if (bus.rf_waddr_o !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d expected 0", bus.rf_waddr_o); end
        n_cmp++; if (bus.rf_wdata_o !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %h expected 0", bus.rf_wdata_o); end
        n_cmp++; if (bus.pend_mask_o !== 32'd0) begin n_err++; $display("FAIL reset_mask: got %h expected 0", bus.pend_mask_o); end
        n_cmp++; if (bus.fwd_hit_o !== 1'b0) begin n_err++; $display("FAIL reset_fwd_hit: got %0b expected 0", bus.fwd_hit_o); end
        n_cmp++; if (bus.lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_lsu_ready: got %0b expected 1", bus.lsu_ready_o); end
        n_cmp++; if (bus.alu_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready: got %0b expected 1", bus.alu_ready_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        clear_log();
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = 5'd5;
        bus.alu_wdata_i = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus.alu_ready_o !== 1'b1) begin n_err++; $display("FAIL single_ready: got %0b expected 1", bus.alu_ready_o); end
        tick();
        idle_inputs();
        bus.fwd_addr_i = 5'd5;
        #1;
        n_cmp++; if (bus.pend_mask_o !== 32'h0000_0020) begin n_err++; $display("FAIL single_mask_set: got %h expected 00000020", bus.pend_mask_o); end
        n_cmp++; if (bus.rf_req_w_o !== 1'b0) begin n_err++; $display("FAIL single_req_c1: got %0b expected 0", bus.rf_req_w_o); end
        n_cmp++; if (bus.fwd_hit_o !== 1'b1 || bus.fwd_data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_fwd: got hit=%0b data=%h expected hit=1 data=deadbeef", bus.fwd_hit_o, bus.fwd_data_o); end
        tick();
        n_cmp++; if (bus.rf_req_w_o !== 1'b0 || bus.rf_waddr_o !== 5'd5) begin n_err++; $display("FAIL single_setup: got req=%0b waddr=%0d expected req=0 waddr=5", bus.rf_req_w_o, bus.rf_waddr_o); end
        tick();
        n_cmp++; if (bus.rf_req_w_o !== 1'b1 || bus.rf_waddr_o !== 5'd5 || bus.rf_wdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_strobe: got req=%0b waddr=%0d wdata=%h expected req=1 waddr=5 wdata=deadbeef", bus.rf_req_w_o, bus.rf_waddr_o, bus.rf_wdata_o); end
        n_cmp++; if (bus.pend_mask_o !== 32'h0000_0020) begin n_err++; $display("FAIL single_mask_strobe: got %h expected 00000020", bus.pend_mask_o); end
        tick();
        n_cmp++; if (bus.rf_req_w_o !== 1'b0) begin n_err++; $display("FAIL single_req_after: got %0b expected 0", bus.rf_req_w_o); end
        n_cmp++; if (bus.pend_mask_o !== 32'd0) begin n_err++; $display("FAIL single_mask_clear: got %h expected 0", bus.pend_mask_o); end
        n_cmp++; if (bus.rf_wdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_hold: got %h expected deadbeef", bus.rf_wdata_o); end
        repeat (4) tick();
        n_cmp++; if (log_addr.size() !== 1) begin n_err++; $display("FAIL single_strobe_count: got %0d expected 1", log_addr.size()); end
        idle_inputs();
    endtask

    task automatic test_dual();
        clear_log();
        bus.lsu_valid_i = 1'b1;
        bus.lsu_rd_i    = 5'd3;
        bus.lsu_wdata_i = 32'h11;
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = 5'd4;
        bus.alu_wdata_i = 32'h22;
        #1;
        n_cmp++; if (bus.lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL dual_lsu_ready: got %0b expected 1", bus.lsu_ready_o); end
        n_cmp++; if (bus.alu_ready_o !== 1'b1) begin n_err++; $display("FAIL dual_alu_ready: got %0b expected 1", bus.alu_ready_o); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.pend_mask_o !== 32'h0000_0018) begin n_err++; $display("FAIL dual_mask: got %h expected 00000018", bus.pend_mask_o); end
        for (int c = 0; c < 20 && log_addr.size() < 2; c++) tick();
        repeat (4) tick();
        n_cmp++;
        if (log_addr.size() !== 2) begin
            n_err++; $display("FAIL dual_count: got %0d expected 2", log_addr.size());
        end else begin
            n_cmp++; if (log_addr[0] !== 5'd3 || log_data[0] !== 32'h11) begin n_err++; $display("FAIL dual_first: got x%0d=%h expected x3=11", log_addr[0], log_data[0]); end
            n_cmp++; if (log_addr[1] !== 5'd4 || log_data[1] !== 32'h22) begin n_err++; $display("FAIL dual_second: got x%0d=%h expected x4=22", log_addr[1], log_data[1]); end
            n_cmp++; if (log_cyc[1] - log_cyc[0] !== 2) begin n_err++; $display("FAIL dual_spacing: got %0d expected 2", log_cyc[1] - log_cyc[0]); end
        end
    endtask

    // Eight writes so the queue actually fills: at one pop per two cycles,
    // six back-to-back pushes into an empty stage peak at three entries.
    task automatic test_back_to_back();
        logic stalled;
        logic lsu_blocked;
        logic accepted;
        int   guard;
        clear_log();
        stalled     = 1'b0;
        lsu_blocked = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bus.alu_valid_i = 1'b1;
            bus.alu_rd_i    = 5'(i);
            bus.alu_wdata_i = 32'(i * 256);
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 50) begin
                #1;
                if (bus.alu_ready_o) begin
                    accepted = 1'b1;
                end else begin
                    stalled = 1'b1;
                    if (!bus.lsu_ready_o) lsu_blocked = 1'b1;
                end
                tick();
                guard++;
            end
            n_cmp++; if (!accepted) begin n_err++; $display("FAIL b2b_accept_x%0d: got timeout expected accept", i); end
        end
        idle_inputs();
        n_cmp++; if (stalled !== 1'b1) begin n_err++; $display("FAIL b2b_full_stall: got %0b expected 1", stalled); end
        n_cmp++; if (lsu_blocked !== 1'b1) begin n_err++; $display("FAIL b2b_full_lsu_ready: got %0b expected 1", lsu_blocked); end
        for (int c = 0; c < 60 && log_addr.size() < 8; c++) tick();
        repeat (4) tick();
        n_cmp++;
        if (log_addr.size() !== 8) begin
            n_err++; $display("FAIL b2b_count: got %0d expected 8", log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (log_addr[i] !== 5'(i + 1) || log_data[i] !== 32'((i + 1) * 256)) begin
                    n_err++; $display("FAIL b2b_order_%0d: got x%0d=%h expected x%0d=%h", i, log_addr[i], log_data[i], i + 1, (i + 1) * 256);
                end
            end
        end
    endtask

    task automatic test_forward();
        int   seen;
        logic done;
        clear_log();
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = 5'd7;
        bus.alu_wdata_i = 32'hAA;
        #1;
        tick();
        bus.alu_wdata_i = 32'hBB;
        #1;
        tick();
        idle_inputs();
        bus.fwd_addr_i = 5'd7;
        #1;
        n_cmp++; if (bus.fwd_hit_o !== 1'b1 || bus.fwd_data_o !== 32'hBB) begin n_err++; $display("FAIL fwd_youngest: got hit=%0b data=%h expected hit=1 data=bb", bus.fwd_hit_o, bus.fwd_data_o); end
        bus.fwd_addr_i = 5'd0;
        #1;
        n_cmp++; if (bus.fwd_hit_o !== 1'b0 || bus.fwd_data_o !== 32'd0) begin n_err++; $display("FAIL fwd_x0: got hit=%0b data=%h expected hit=0 data=0", bus.fwd_hit_o, bus.fwd_data_o); end
        bus.fwd_addr_i = 5'd9;
        #1;
        n_cmp++; if (bus.fwd_hit_o !== 1'b0 || bus.fwd_data_o !== 32'd0) begin n_err++; $display("FAIL fwd_miss: got hit=%0b data=%h expected hit=0 data=0", bus.fwd_hit_o, bus.fwd_data_o); end
        bus.fwd_addr_i = 5'd7;
        seen = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (bus.rf_req_w_o) seen++;
            if (seen == 2 && !bus.rf_req_w_o) begin
                n_cmp++; if (bus.pend_mask_o[7] !== 1'b0) begin n_err++; $display("FAIL fwd_mask_clear: got %0b expected 0", bus.pend_mask_o[7]); end
                done = 1'b1;
            end else begin
                n_cmp++; if (bus.pend_mask_o[7] !== 1'b1) begin n_err++; $display("FAIL fwd_mask_held_c%0d: got %0b expected 1", c, bus.pend_mask_o[7]); end
            end
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL fwd_two_strobes: got %0d strobes expected 2", seen); end
        n_cmp++;
        if (log_data.size() !== 2) begin
            n_err++; $display("FAIL fwd_log_count: got %0d expected 2", log_data.size());
        end else if (log_data[0] !== 32'hAA || log_data[1] !== 32'hBB) begin
            n_err++; $display("FAIL fwd_log_order: got %h,%h expected aa,bb", log_data[0], log_data[1]);
        end
        idle_inputs();
    endtask

    task automatic test_rd_zero();
        clear_log();
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = 5'd0;
        bus.alu_wdata_i = 32'hFFFF;
        #1;
        n_cmp++; if (bus.alu_ready_o !== 1'b1) begin n_err++; $display("FAIL rd0_ready: got %0b expected 1", bus.alu_ready_o); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.pend_mask_o !== 32'd0) begin n_err++; $display("FAIL rd0_mask: got %h expected 0", bus.pend_mask_o); end
        repeat (6) tick();
        n_cmp++; if (log_addr.size() !== 0) begin n_err++; $display("FAIL rd0_no_strobe: got %0d expected 0", log_addr.size()); end
        n_cmp++; if (bus.pend_mask_o !== 32'd0) begin n_err++; $display("FAIL rd0_mask_late: got %h expected 0", bus.pend_mask_o); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        bus.lsu_valid_i = 1'b1;
        bus.lsu_rd_i    = 5'd3;
        bus.lsu_wdata_i = 32'h33;
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = 5'd4;
        bus.alu_wdata_i = 32'h44;
        #1;
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (bus.rf_req_w_o !== 1'b0 || bus.rf_waddr_o !== 5'd3) begin n_err++; $display("FAIL rstmid_setup: got req=%0b waddr=%0d expected req=0 waddr=3", bus.rf_req_w_o, bus.rf_waddr_o); end
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.rf_req_w_o !== 1'b0) begin n_err++; $display("FAIL rstmid_req: got %0b expected 0", bus.rf_req_w_o); end
        n_cmp++; if (bus.pend_mask_o !== 32'd0) begin n_err++; $display("FAIL rstmid_mask: got %h expected 0", bus.pend_mask_o); end
        n_cmp++; if (bus.lsu_ready_o !== 1'b1 || bus.alu_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got lsu=%0b alu=%0b expected 1 1", bus.lsu_ready_o, bus.alu_ready_o); end
        rst = 1'b0;
        repeat (8) tick();
        n_cmp++; if (log_addr.size() !== 0) begin n_err++; $display("FAIL rstmid_no_strobe: got %0d expected 0", log_addr.size()); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_forward();
        test_rd_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
